// File: rtl/cntr_control.sv
// Control FSM for one counter datapath: issues clear/increment/hold commands from
// enable, clear handshake and terminal-count detection on the fed-back count.
package cntr_control_pkg;
  typedef enum logic [1:0] {
    op_state_1 = 2'd0,  // clear
    op_state_2 = 2'd1,  // increment
    op_state_3 = 2'd2   // hold / publish
  } cntr_operations_t;
endpackage

module cntr_control
  import cntr_control_pkg::*;
#(
  parameter logic [31:0] MAX_CNT   = 32'd1000,
  parameter logic        AUTO_WRAP = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_sig,
  input  logic             clr_req,
  output logic             clr_ack,
  input  logic [31:0]      cnt_in,
  output cntr_operations_t operation,
  output logic             busy,
  output logic             tc_pulse,
  output logic [15:0]      wrap_cnt,
  output logic [2:0]       state_out
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_COUNT = 3'd1,
    S_PAUSE = 3'd2,
    S_CLEAR = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic        clr_ack_q;
  logic        tc_q, tc_d;
  logic        busy_q;
  logic [15:0] wrap_q, wrap_d;
  logic        armed_q, armed_d;
  logic        clr_go_s;
  logic        terminal_s;

  // A held clr_req must be released for a cycle before it can start another clear.
  assign clr_go_s   = clr_req & armed_q;
  assign terminal_s = (cnt_in >= MAX_CNT);

  // Next-state, datapath command and side-effect decode
  always_comb begin
    state_d   = state_q;
    operation = op_state_3;
    tc_d      = 1'b0;
    wrap_d    = wrap_q;
    if (!clr_req) begin
      armed_d = 1'b1;
    end else begin
      armed_d = armed_q;
    end
    case (state_q)
      S_IDLE: begin
        if (clr_go_s) begin
          state_d = S_CLEAR;
        end else if (en_sig) begin
          state_d = S_COUNT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_COUNT: begin
        if (clr_go_s) begin
          state_d = S_CLEAR;
        end else if (en_sig && terminal_s) begin
          tc_d = 1'b1;
          if (AUTO_WRAP) begin
            operation = op_state_1;
            wrap_d    = (wrap_q == 16'hFFFF) ? wrap_q : wrap_q + 16'd1;
          end else begin
            state_d = S_DONE;
          end
        end else if (en_sig) begin
          operation = op_state_2;
        end else begin
          state_d = S_PAUSE;
        end
      end
      S_PAUSE: begin
        if (clr_go_s) begin
          state_d = S_CLEAR;
        end else if (en_sig) begin
          state_d = S_COUNT;
        end else begin
          state_d = S_PAUSE;
        end
      end
      S_CLEAR: begin
        operation = op_state_1;
        wrap_d    = 16'd0;
        armed_d   = 1'b0;
        state_d   = S_IDLE;
      end
      S_DONE: begin
        if (clr_go_s) begin
          state_d = S_CLEAR;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // Reset forces the datapath to clear while the FSM itself resets.
    if (rst) begin
      operation = op_state_1;
    end else begin
      operation = operation;
    end
  end

  // State and registered status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      clr_ack_q <= 1'b0;
      tc_q      <= 1'b0;
      busy_q    <= 1'b0;
      wrap_q    <= 16'd0;
      armed_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      clr_ack_q <= (state_q == S_CLEAR);
      tc_q      <= tc_d;
      busy_q    <= (state_d == S_COUNT);
      wrap_q    <= wrap_d;
      armed_q   <= armed_d;
    end
  end

  assign clr_ack   = clr_ack_q;
  assign tc_pulse  = tc_q;
  assign busy      = busy_q;
  assign wrap_cnt  = wrap_q;
  assign state_out = state_q;

endmodule

// File: tb/tb_cntr_control.sv
// Directed-vector bench: two controllers (wrapping and stopping) each closing the
// loop through a small behavioural counter datapath.
module tb_cntr_control;
  import cntr_control_pkg::*;

  typedef struct {
    logic             rst;
    logic             en;
    logic             clr;
    logic             frc;
    logic [31:0]      frc_val;
    cntr_operations_t op;
    logic [2:0]       st;
    logic [31:0]      cnt;
    logic             ack;
    logic             tc;
    logic [15:0]      wrap;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic en_a, clr_a, en_b, clr_b, frc_b;
  logic [31:0] frc_val_b;
  logic [31:0] dp_a, dp_b, cnt_a, cnt_b;
  cntr_operations_t op_a, op_b;
  logic ack_a, ack_b, busy_a, busy_b, tc_a, tc_b;
  logic [15:0] wrap_a, wrap_b;
  logic [2:0] st_a, st_b;

  int n_vec = 0;
  int n_cmp = 0;
  int n_err = 0;
  vec_t tab_a[$];
  vec_t tab_b[$];

  always #5 clk = ~clk;

  cntr_control #(.MAX_CNT(32'd5), .AUTO_WRAP(1'b1)) u_wrap (
    .clk(clk), .rst(rst), .en_sig(en_a), .clr_req(clr_a), .clr_ack(ack_a),
    .cnt_in(cnt_a), .operation(op_a), .busy(busy_a), .tc_pulse(tc_a),
    .wrap_cnt(wrap_a), .state_out(st_a));

  cntr_control #(.MAX_CNT(32'd5), .AUTO_WRAP(1'b0)) u_stop (
    .clk(clk), .rst(rst), .en_sig(en_b), .clr_req(clr_b), .clr_ack(ack_b),
    .cnt_in(cnt_b), .operation(op_b), .busy(busy_b), .tc_pulse(tc_b),
    .wrap_cnt(wrap_b), .state_out(st_b));

  // Counter datapaths obeying the controllers' commands
  always @(posedge clk) begin
    case (op_a)
      op_state_1: dp_a <= 32'd0;
      op_state_2: dp_a <= dp_a + 32'd1;
      default:    dp_a <= dp_a;
    endcase
    case (op_b)
      op_state_1: dp_b <= 32'd0;
      op_state_2: dp_b <= dp_b + 32'd1;
      default:    dp_b <= dp_b;
    endcase
  end

  assign cnt_a = dp_a;
  assign cnt_b = frc_b ? frc_val_b : dp_b;

  function automatic vec_t mk(input logic r, input logic e, input logic c,
                              input cntr_operations_t o, input logic [2:0] s,
                              input logic [31:0] n, input logic a, input logic t,
                              input logic [15:0] w, input logic f = 1'b0,
                              input logic [31:0] fv = 32'd0);
    vec_t v;
    v.rst = r; v.en = e; v.clr = c; v.frc = f; v.frc_val = fv;
    v.op = o; v.st = s; v.cnt = n; v.ack = a; v.tc = t; v.wrap = w;
    return v;
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s row %0d: got %0h, expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input bit use_b, input int idx);
    @(negedge clk);
    rst = v.rst;
    if (use_b) begin
      en_b = v.en; clr_b = v.clr; frc_b = v.frc; frc_val_b = v.frc_val;
    end else begin
      en_a = v.en; clr_a = v.clr;
    end
    #2;
    n_vec++;
    if (use_b) begin
      check("stop.op",    idx, 32'(op_b),   32'(v.op));
      check("stop.state", idx, 32'(st_b),   32'(v.st));
      check("stop.cnt",   idx, cnt_b,       v.cnt);
      check("stop.ack",   idx, 32'(ack_b),  32'(v.ack));
      check("stop.tc",    idx, 32'(tc_b),   32'(v.tc));
      check("stop.wrap",  idx, 32'(wrap_b), 32'(v.wrap));
      check("stop.busy",  idx, 32'(busy_b), 32'(v.st == 3'd1));
    end else begin
      check("wrap.op",    idx, 32'(op_a),   32'(v.op));
      check("wrap.state", idx, 32'(st_a),   32'(v.st));
      check("wrap.cnt",   idx, cnt_a,       v.cnt);
      check("wrap.ack",   idx, 32'(ack_a),  32'(v.ack));
      check("wrap.tc",    idx, 32'(tc_a),   32'(v.tc));
      check("wrap.wrap",  idx, 32'(wrap_a), 32'(v.wrap));
      check("wrap.busy",  idx, 32'(busy_a), 32'(v.st == 3'd1));
    end
  endtask

  initial begin
    // Wrapping controller: count/wrap twice, pause, clear, clear+enable, reset at 3
    tab_a.push_back(mk(1'b0, 1'b1, 1'b0, op_state_3, 3'd0, 32'd0, 1'b0, 1'b0, 16'd0));
    for (int i = 0; i < 5; i++)
      tab_a.push_back(mk(1'b0, 1'b1, 1'b0, op_state_2, 3'd1, 32'(i), 1'b0, 1'b0, 16'd0));
    tab_a.push_back(mk(1'b0, 1'b1, 1'b0, op_state_1, 3'd1, 32'd5, 1'b0, 1'b0, 16'd0));
    tab_a.push_back(mk(1'b0, 1'b1, 1'b0, op_state_2, 3'd1, 32'd0, 1'b0, 1'b1, 16'd1));
    for (int i = 1; i < 5; i++)
      tab_a.push_back(mk(1'b0, 1'b1, 1'b0, op_state_2, 3'd1, 32'(i), 1'b0, 1'b0, 16'd1));
    tab_a.push_back(mk(1'b0, 1'b1, 1'b0, op_state_1, 3'd1, 32'd5, 1'b0, 1'b0, 16'd1));
    tab_a.push_back(mk(1'b0, 1'b1, 1'b0, op_state_2, 3'd1, 32'd0, 1'b0, 1'b1, 16'd2));
    tab_a.push_back(mk(1'b0, 1'b1, 1'b0, op_state_2, 3'd1, 32'd1, 1'b0, 1'b0, 16'd2));
    tab_a.push_back(mk(1'b0, 1'b1, 1'b0, op_state_2, 3'd1, 32'd2, 1'b0, 1'b0, 16'd2));
    tab_a.push_back(mk(1'b0, 1'b0, 1'b0, op_state_3, 3'd1, 32'd3, 1'b0, 1'b0, 16'd2));
    for (int i = 0; i < 3; i++)
      tab_a.push_back(mk(1'b0, 1'b0, 1'b0, op_state_3, 3'd2, 32'd3, 1'b0, 1'b0, 16'd2));
    tab_a.push_back(mk(1'b0, 1'b1, 1'b0, op_state_3, 3'd2, 32'd3, 1'b0, 1'b0, 16'd2));
    tab_a.push_back(mk(1'b0, 1'b1, 1'b0, op_state_2, 3'd1, 32'd3, 1'b0, 1'b0, 16'd2));
    tab_a.push_back(mk(1'b0, 1'b1, 1'b1, op_state_3, 3'd1, 32'd4, 1'b0, 1'b0, 16'd2));
    tab_a.push_back(mk(1'b0, 1'b0, 1'b1, op_state_1, 3'd3, 32'd4, 1'b0, 1'b0, 16'd2));
    tab_a.push_back(mk(1'b0, 1'b0, 1'b1, op_state_3, 3'd0, 32'd0, 1'b1, 1'b0, 16'd0));
    tab_a.push_back(mk(1'b0, 1'b0, 1'b0, op_state_3, 3'd0, 32'd0, 1'b0, 1'b0, 16'd0));
    tab_a.push_back(mk(1'b0, 1'b1, 1'b1, op_state_3, 3'd0, 32'd0, 1'b0, 1'b0, 16'd0));
    tab_a.push_back(mk(1'b0, 1'b1, 1'b1, op_state_1, 3'd3, 32'd0, 1'b0, 1'b0, 16'd0));
    tab_a.push_back(mk(1'b0, 1'b1, 1'b1, op_state_3, 3'd0, 32'd0, 1'b1, 1'b0, 16'd0));
    for (int i = 0; i < 5; i++)
      tab_a.push_back(mk(1'b0, 1'b1, 1'b0, op_state_2, 3'd1, 32'(i), 1'b0, 1'b0, 16'd0));
    tab_a.push_back(mk(1'b0, 1'b1, 1'b0, op_state_1, 3'd1, 32'd5, 1'b0, 1'b0, 16'd0));
    tab_a.push_back(mk(1'b0, 1'b1, 1'b0, op_state_2, 3'd1, 32'd0, 1'b0, 1'b1, 16'd1));
    tab_a.push_back(mk(1'b0, 1'b1, 1'b0, op_state_2, 3'd1, 32'd1, 1'b0, 1'b0, 16'd1));
    tab_a.push_back(mk(1'b0, 1'b1, 1'b0, op_state_2, 3'd1, 32'd2, 1'b0, 1'b0, 16'd1));
    tab_a.push_back(mk(1'b1, 1'b1, 1'b0, op_state_1, 3'd1, 32'd3, 1'b0, 1'b0, 16'd1));
    tab_a.push_back(mk(1'b0, 1'b0, 1'b0, op_state_3, 3'd0, 32'd0, 1'b0, 1'b0, 16'd0));

    // Stopping controller: reach DONE, ignore enable, clear out, out-of-range count
    tab_b.push_back(mk(1'b0, 1'b1, 1'b0, op_state_3, 3'd0, 32'd0, 1'b0, 1'b0, 16'd0));
    for (int i = 0; i < 5; i++)
      tab_b.push_back(mk(1'b0, 1'b1, 1'b0, op_state_2, 3'd1, 32'(i), 1'b0, 1'b0, 16'd0));
    tab_b.push_back(mk(1'b0, 1'b1, 1'b0, op_state_3, 3'd1, 32'd5, 1'b0, 1'b0, 16'd0));
    tab_b.push_back(mk(1'b0, 1'b1, 1'b0, op_state_3, 3'd4, 32'd5, 1'b0, 1'b1, 16'd0));
    tab_b.push_back(mk(1'b0, 1'b1, 1'b0, op_state_3, 3'd4, 32'd5, 1'b0, 1'b0, 16'd0));
    tab_b.push_back(mk(1'b0, 1'b0, 1'b0, op_state_3, 3'd4, 32'd5, 1'b0, 1'b0, 16'd0));
    tab_b.push_back(mk(1'b0, 1'b1, 1'b1, op_state_3, 3'd4, 32'd5, 1'b0, 1'b0, 16'd0));
    tab_b.push_back(mk(1'b0, 1'b1, 1'b1, op_state_1, 3'd3, 32'd5, 1'b0, 1'b0, 16'd0));
    tab_b.push_back(mk(1'b0, 1'b1, 1'b0, op_state_3, 3'd0, 32'd0, 1'b1, 1'b0, 16'd0));
    tab_b.push_back(mk(1'b0, 1'b1, 1'b0, op_state_2, 3'd1, 32'd0, 1'b0, 1'b0, 16'd0));
    tab_b.push_back(mk(1'b0, 1'b1, 1'b0, op_state_2, 3'd1, 32'd4, 1'b0, 1'b0, 16'd0,
                       1'b1, 32'd4));
    tab_b.push_back(mk(1'b0, 1'b1, 1'b0, op_state_3, 3'd1, 32'h8000_0000, 1'b0, 1'b0, 16'd0,
                       1'b1, 32'h8000_0000));
    tab_b.push_back(mk(1'b0, 1'b1, 1'b0, op_state_3, 3'd4, 32'd2, 1'b0, 1'b1, 16'd0));

    rst = 1'b1; en_a = 1'b0; clr_a = 1'b0; en_b = 1'b0; clr_b = 1'b0;
    frc_b = 1'b0; frc_val_b = 32'd0;

    // Reset state, sampled mid-cycle while rst is still asserted
    repeat (2) @(negedge clk);
    #2;
    n_vec++;
    check("rst.op_wrap",  0, 32'(op_a),   32'(op_state_1));
    check("rst.op_stop",  0, 32'(op_b),   32'(op_state_1));
    check("rst.state",    0, 32'(st_a),   32'd0);
    check("rst.busy",     0, 32'(busy_a), 32'd0);
    check("rst.ack",      0, 32'(ack_a),  32'd0);
    check("rst.tc",       0, 32'(tc_a),   32'd0);
    check("rst.wrap",     0, 32'(wrap_a), 32'd0);

    foreach (tab_a[i]) apply(tab_a[i], 1'b0, i);
    foreach (tab_b[i]) apply(tab_b[i], 1'b1, i);

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
